// File: rtl/sprite_pkg.sv
// -----------------------------------------------------------------------------
// sprite_pkg
// Shared definitions for the sprite renderer:
//   - coordinate width
//   - RRRGGGBB colour field widths and default colours
//   - update FSM state encoding
//   - latched button bundle
// -----------------------------------------------------------------------------
package sprite_pkg;

    localparam int COORD_W = 10;

    localparam int R_W   = 3;
    localparam int G_W   = 3;
    localparam int B_W   = 2;
    localparam int RGB_W = R_W + G_W + B_W;

    localparam logic [RGB_W-1:0] BOX_COLOR_DEF = 8'hE0;
    localparam logic [RGB_W-1:0] BG_COLOR_DEF  = 8'h03;

    typedef enum logic [1:0] {
        S_WAIT   = 2'd0,
        S_LATCH  = 2'd1,
        S_MOVE_X = 2'd2,
        S_MOVE_Y = 2'd3
    } state_t;

    typedef struct packed {
        logic up;
        logic down;
        logic left;
        logic right;
    } btn_t;

endpackage

// File: rtl/sprite_axis_step.sv
// -----------------------------------------------------------------------------
// sprite_axis_step
// Combinational step-and-clamp for one axis of the sprite position.
//   pos      : current edge position
//   neg_btn  : move towards 0 (LEFT / UP)
//   pos_btn  : move towards MAX (RIGHT / DOWN)
//   next_pos : position after one step, clamped to [0, MAX]
// Both or neither button pressed leaves the position unchanged.
// -----------------------------------------------------------------------------
module sprite_axis_step
    import sprite_pkg::*;
#(
    parameter int STEP = 4,
    parameter int MAX  = 608
) (
    input  logic [COORD_W-1:0] pos,
    input  logic               neg_btn,
    input  logic               pos_btn,
    output logic [COORD_W-1:0] next_pos
);

    // One extra bit so pos+STEP cannot wrap before the clamp compare.
    localparam logic [COORD_W:0] STEP_W = (COORD_W+1)'(STEP);
    localparam logic [COORD_W:0] MAX_W  = (COORD_W+1)'(MAX);

    logic [COORD_W:0] sum;
    assign sum = {1'b0, pos} + STEP_W;

    always_comb begin
        // NOTE: default assignment first so every path drives next_pos and no latch is inferred.
        next_pos = pos;
        if (neg_btn && !pos_btn) begin
            if ({1'b0, pos} < STEP_W)
                next_pos = '0;
            else
                next_pos = pos - STEP_W[COORD_W-1:0];
        end else if (pos_btn && !neg_btn) begin
            if (sum > MAX_W)
                next_pos = MAX_W[COORD_W-1:0];
            else
                next_pos = sum[COORD_W-1:0];
        end
    end

endmodule

// File: rtl/sprite_renderer.sv
// -----------------------------------------------------------------------------
// sprite_renderer
// Draws one solid rectangle over a flat background, one pixel per clock, and
// moves it once per frame from the game-controller buttons.
// Ports:
//   i_CLK, i_RESET           pixel clock, async active-high reset
//   i_PIX_X/Y, i_PIX_VALID   current coordinate from the timing stage
//   i_FRAME_START            one-cycle pulse at start of vertical blanking
//   i_BTN_UP/DOWN/LEFT/RIGHT debounced move requests
//   o_RGB, o_RGB_VALID       registered pixel colour (RRRGGGBB) and valid
//   o_POS_X/Y                sprite left/top edge
//   o_FRAME_CNT              completed position updates, wraps at 256
// -----------------------------------------------------------------------------
module sprite_renderer
    import sprite_pkg::*;
#(
    parameter int               H_ACTIVE  = 640,
    parameter int               V_ACTIVE  = 480,
    parameter int               BOX_W     = 32,
    parameter int               BOX_H     = 32,
    parameter int               STEP      = 4,
    parameter int               INIT_X    = 304,
    parameter int               INIT_Y    = 224,
    parameter logic [RGB_W-1:0] BOX_COLOR = BOX_COLOR_DEF,
    parameter logic [RGB_W-1:0] BG_COLOR  = BG_COLOR_DEF
) (
    input  logic               i_CLK,
    input  logic               i_RESET,
    input  logic [COORD_W-1:0] i_PIX_X,
    input  logic [COORD_W-1:0] i_PIX_Y,
    input  logic               i_PIX_VALID,
    input  logic               i_FRAME_START,
    input  logic               i_BTN_UP,
    input  logic               i_BTN_DOWN,
    input  logic               i_BTN_LEFT,
    input  logic               i_BTN_RIGHT,
    output logic [RGB_W-1:0]   o_RGB,
    output logic               o_RGB_VALID,
    output logic [COORD_W-1:0] o_POS_X,
    output logic [COORD_W-1:0] o_POS_Y,
    output logic [7:0]         o_FRAME_CNT
);

    localparam logic [COORD_W:0]   BOX_W_W = (COORD_W+1)'(BOX_W);
    localparam logic [COORD_W:0]   BOX_H_W = (COORD_W+1)'(BOX_H);
    localparam logic [COORD_W-1:0] INIT_XV = COORD_W'(INIT_X);
    localparam logic [COORD_W-1:0] INIT_YV = COORD_W'(INIT_Y);

    state_t             state;
    btn_t               btn_q;
    logic [COORD_W-1:0] next_x;
    logic [COORD_W-1:0] next_y;
    logic               hit;

    // ---------------------------------------------------------------- pixel path
    // 11-bit compares: pos + BOX size may exceed the 10-bit coordinate range.
    assign hit = ({1'b0, i_PIX_X} >= {1'b0, o_POS_X}) &&
                 ({1'b0, i_PIX_X} <  ({1'b0, o_POS_X} + BOX_W_W)) &&
                 ({1'b0, i_PIX_Y} >= {1'b0, o_POS_Y}) &&
                 ({1'b0, i_PIX_Y} <  ({1'b0, o_POS_Y} + BOX_H_W));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_CLK or posedge i_RESET) begin
        if (i_RESET) begin
            o_RGB       <= '0;
            o_RGB_VALID <= 1'b0;
        end else begin
            o_RGB_VALID <= i_PIX_VALID;
            if (!i_PIX_VALID)
                o_RGB <= '0;
            else if (hit)
                o_RGB <= BOX_COLOR;
            else
                o_RGB <= BG_COLOR;
        end
    end

    // ------------------------------------------------------------- axis steppers
    sprite_axis_step #(.STEP(STEP), .MAX(H_ACTIVE - BOX_W)) u_step_x (
        .pos      (o_POS_X),
        .neg_btn  (btn_q.left),
        .pos_btn  (btn_q.right),
        .next_pos (next_x)
    );

    sprite_axis_step #(.STEP(STEP), .MAX(V_ACTIVE - BOX_H)) u_step_y (
        .pos      (o_POS_Y),
        .neg_btn  (btn_q.up),
        .pos_btn  (btn_q.down),
        .next_pos (next_y)
    );

    // ---------------------------------------------------------------- update FSM
    // Position only changes in blanking (MOVE_X/MOVE_Y); frame starts arriving
    // outside S_WAIT are dropped rather than queued.
    always_ff @(posedge i_CLK or posedge i_RESET) begin
        if (i_RESET) begin
            state       <= S_WAIT;
            btn_q       <= '0;
            o_POS_X     <= INIT_XV;
            o_POS_Y     <= INIT_YV;
            o_FRAME_CNT <= '0;
        end else begin
            case (state)
                S_WAIT: begin
                    if (i_FRAME_START)
                        state <= S_LATCH;
                end
                S_LATCH: begin
                    btn_q <= '{up: i_BTN_UP, down: i_BTN_DOWN,
                               left: i_BTN_LEFT, right: i_BTN_RIGHT};
                    state <= S_MOVE_X;
                end
                S_MOVE_X: begin
                    o_POS_X <= next_x;
                    state   <= S_MOVE_Y;
                end
                S_MOVE_Y: begin
                    o_POS_Y     <= next_y;
                    o_FRAME_CNT <= o_FRAME_CNT + 8'd1;
                    state       <= S_WAIT;
                end
                default: state <= S_WAIT;
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_renderer.sv
// -----------------------------------------------------------------------------
// tb_sprite_renderer
// Directed self-checking bench for sprite_renderer. Inputs change on the
// falling edge, outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_sprite_renderer;

    logic       i_CLK = 1'b0;
    logic       i_RESET;
    logic [9:0] i_PIX_X;
    logic [9:0] i_PIX_Y;
    logic       i_PIX_VALID;
    logic       i_FRAME_START;
    logic       i_BTN_UP;
    logic       i_BTN_DOWN;
    logic       i_BTN_LEFT;
    logic       i_BTN_RIGHT;
    logic [7:0] o_RGB;
    logic       o_RGB_VALID;
    logic [9:0] o_POS_X;
    logic [9:0] o_POS_Y;
    logic [7:0] o_FRAME_CNT;

    int n_checks = 0;
    int n_errors = 0;

    sprite_renderer dut (
        .i_CLK         (i_CLK),
        .i_RESET       (i_RESET),
        .i_PIX_X       (i_PIX_X),
        .i_PIX_Y       (i_PIX_Y),
        .i_PIX_VALID   (i_PIX_VALID),
        .i_FRAME_START (i_FRAME_START),
        .i_BTN_UP      (i_BTN_UP),
        .i_BTN_DOWN    (i_BTN_DOWN),
        .i_BTN_LEFT    (i_BTN_LEFT),
        .i_BTN_RIGHT   (i_BTN_RIGHT),
        .o_RGB         (o_RGB),
        .o_RGB_VALID   (o_RGB_VALID),
        .o_POS_X       (o_POS_X),
        .o_POS_Y       (o_POS_Y),
        .o_FRAME_CNT   (o_FRAME_CNT)
    );

    always #5 i_CLK = ~i_CLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
                     tag, actual, actual, expected, expected);
        end
    endtask

    task automatic set_btn(input logic up, input logic down,
                           input logic left, input logic right);
        i_BTN_UP    = up;
        i_BTN_DOWN  = down;
        i_BTN_LEFT  = left;
        i_BTN_RIGHT = right;
    endtask

    // One full update: pulse FRAME_START, then WAIT->LATCH->MOVE_X->MOVE_Y->WAIT.
    // Returns with the update complete, sampled at a falling edge.
    task automatic do_frame(input logic up, input logic down,
                            input logic left, input logic right);
        set_btn(up, down, left, right);
        @(negedge i_CLK) i_FRAME_START = 1'b1;
        @(negedge i_CLK) i_FRAME_START = 1'b0;
        repeat (3) @(negedge i_CLK);
    endtask

    // Present one coordinate; the result appears after the next rising edge.
    task automatic pixel(input int x, input int y, input logic v,
                         input string tag, input int exp_rgb);
        @(negedge i_CLK);
        i_PIX_X     = 10'(x);
        i_PIX_Y     = 10'(y);
        i_PIX_VALID = v;
        @(negedge i_CLK);
        check(tag, int'(o_RGB), exp_rgb);
        check({tag, "_valid"}, int'(o_RGB_VALID), int'(v));
    endtask

    task automatic pulse_reset();
        @(negedge i_CLK) i_RESET = 1'b1;
        @(negedge i_CLK) i_RESET = 1'b0;
    endtask

    initial begin
        i_RESET       = 1'b1;
        i_PIX_X       = '0;
        i_PIX_Y       = '0;
        i_PIX_VALID   = 1'b0;
        i_FRAME_START = 1'b0;
        set_btn(0, 0, 0, 0);

        // 1. reset state and basic pixel colours
        repeat (2) @(negedge i_CLK);
        check("rst_rgb",   int'(o_RGB),       0);
        check("rst_valid", int'(o_RGB_VALID), 0);
        check("rst_x",     int'(o_POS_X),     304);
        check("rst_y",     int'(o_POS_Y),     224);
        check("rst_cnt",   int'(o_FRAME_CNT), 0);
        i_RESET = 1'b0;
        pixel(320, 240, 1'b1, "px_center", 8'hE0);
        pixel(0,   0,   1'b1, "px_origin", 8'h03);
        pixel(303, 224, 1'b1, "px_left_of_box", 8'h03);
        pixel(335, 255, 1'b1, "px_box_corner", 8'hE0);

        // 2. move right, then saturate at 640-32
        do_frame(0, 0, 0, 1);
        check("right1_x",   int'(o_POS_X),     308);
        check("right1_y",   int'(o_POS_Y),     224);
        check("right1_cnt", int'(o_FRAME_CNT), 1);
        for (int f = 0; f < 199; f++) begin
            do_frame(0, 0, 0, 1);
            check("right_le_max", int'(o_POS_X <= 10'd608), 1);
        end
        check("right_sat_x", int'(o_POS_X),     608);
        check("right_cnt",   int'(o_FRAME_CNT), 200);

        // 3. move left to 0 and stay; move up to 0 and stay
        for (int f = 0; f < 153; f++) do_frame(0, 0, 1, 0);
        check("left_sat_x", int'(o_POS_X), 0);
        for (int f = 0; f < 60; f++) do_frame(1, 0, 0, 0);
        check("up_sat_y",   int'(o_POS_Y), 0);
        check("up_cnt",     int'(o_FRAME_CNT), (200 + 153 + 60) % 256);

        // 4. opposing X buttons cancel, Y still moves
        pulse_reset();
        check("rst2_x", int'(o_POS_X), 304);
        check("rst2_y", int'(o_POS_Y), 224);
        do_frame(0, 1, 1, 1);
        check("cancel_x", int'(o_POS_X),     304);
        check("down_y",   int'(o_POS_Y),     228);
        check("mix_cnt",  int'(o_FRAME_CNT), 1);

        // 5a. second FRAME_START while in S_LATCH is ignored
        set_btn(0, 0, 0, 1);
        @(negedge i_CLK) i_FRAME_START = 1'b1;
        @(negedge i_CLK) i_FRAME_START = 1'b1;   // FSM now in S_LATCH
        @(negedge i_CLK) i_FRAME_START = 1'b0;
        repeat (6) @(negedge i_CLK);
        check("dbl_fs_x",   int'(o_POS_X),     308);
        check("dbl_fs_cnt", int'(o_FRAME_CNT), 2);

        // 5b. buttons changed outside S_LATCH have no effect
        set_btn(0, 0, 0, 1);
        @(negedge i_CLK) i_FRAME_START = 1'b1;
        @(negedge i_CLK) i_FRAME_START = 1'b0;   // S_LATCH samples RIGHT here
        @(negedge i_CLK) set_btn(1, 0, 1, 0);    // now in S_MOVE_X
        repeat (2) @(negedge i_CLK);
        check("late_btn_x", int'(o_POS_X), 312);
        check("late_btn_y", int'(o_POS_Y), 228);
        set_btn(0, 0, 0, 0);

        // 5c. reset during S_MOVE_X discards the partial move, asynchronously
        set_btn(0, 0, 0, 1);
        @(negedge i_CLK) i_FRAME_START = 1'b1;
        @(negedge i_CLK) i_FRAME_START = 1'b0;
        @(negedge i_CLK);                        // FSM in S_MOVE_X
        i_RESET = 1'b1;
        #1;
        check("async_rst_x",   int'(o_POS_X),     304);
        check("async_rst_y",   int'(o_POS_Y),     224);
        check("async_rst_cnt", int'(o_FRAME_CNT), 0);
        @(negedge i_CLK) i_RESET = 1'b0;
        repeat (6) @(negedge i_CLK);
        check("post_rst_idle_x",   int'(o_POS_X),     304);
        check("post_rst_idle_cnt", int'(o_FRAME_CNT), 0);
        do_frame(0, 0, 0, 1);
        check("post_rst_x",   int'(o_POS_X),     308);
        check("post_rst_cnt", int'(o_FRAME_CNT), 1);

        // 6. sprite at (0,0): box edges and invalid pixels
        for (int f = 0; f < 80; f++) do_frame(1, 0, 1, 0);
        check("corner_x", int'(o_POS_X), 0);
        check("corner_y", int'(o_POS_Y), 0);
        pixel(31, 31, 1'b1, "px_31_31", 8'hE0);
        pixel(32, 31, 1'b1, "px_32_31", 8'h03);
        pixel(31, 32, 1'b1, "px_31_32", 8'h03);
        pixel(0,  0,  1'b1, "px_0_0",   8'hE0);
        pixel(5,  5,  1'b0, "px_invalid", 8'h00);

        // 6b. frame counter wraps after 256 updates
        pulse_reset();
        for (int f = 0; f < 255; f++) do_frame(0, 0, 0, 0);
        check("cnt_255", int'(o_FRAME_CNT), 255);
        do_frame(0, 0, 0, 0);
        check("cnt_wrap", int'(o_FRAME_CNT), 0);
        check("idle_x",   int'(o_POS_X),     304);
        check("idle_y",   int'(o_POS_Y),     224);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
